// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Sequential front end for a combinational single-precision FPU
//   (control=0 add, control=1 multiply). Requests are queued, issued to the
//   FPU one at a time and held for SETTLE_CYCLES. The FPU result is then
//   captured and offered downstream over a valid/ready handshake.
//
// Parameters
//   SETTLE_CYCLES  cycles fpu_* are held before fpu_result is sampled (1..15)
//   FIFO_DEPTH     request queue entries (power of two, >= 2)
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   in_valid/in_ready            request handshake; in_ready = !full
//   in_a, in_b, in_ctrl          operands and opcode of a request
//   fpu_a, fpu_b, fpu_control    operands driven to the FPU
//   fpu_result                   FPU output
//   out_valid/out_ready          result handshake
//   out_result                   captured FPU result
//   busy                         FSM not idle or queue non-empty
//   op_count                     completed result handshakes, wraps at 256
//   out_flags                    {is_nan, is_inf, is_zero, sign} of out_result,
//                                present only when FPU_RESULT_FLAGS_EN is defined
//
// state  | meaning
// IDLE   | no request in flight; pops the queue head when one is available
// SETTLE | fpu_* driven, down-counter running toward terminal count 0
// HOLD   | out_result valid, waiting for out_ready
module fpu_issue_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic        in_ctrl,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic        fpu_control,
   input  logic [31:0] fpu_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        busy,
   output logic [7:0]  op_count
`ifdef FPU_RESULT_FLAGS_EN
   ,
   output logic [3:0]  out_flags
`endif
);

   localparam int         AW          = $clog2(FIFO_DEPTH);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  settle_cnt;

   // entry layout: {a[31:0], b[31:0], ctrl}
   logic [64:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [64:0] head;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;

   // The extra pointer MSB separates full (wrap bits differ) from empty.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign head     = mem[rd_ptr[AW-1:0]];

   // Head leaves the queue when idle, or on the result handshake so the next
   // request issues back-to-back.
   assign pop  = !empty && ((state == IDLE) || ((state == HOLD) && out_ready));
   assign busy = (state != IDLE) || !empty;

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {in_a, in_b, in_ctrl};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

`ifdef FPU_RESULT_FLAGS_EN
   function automatic logic [3:0] result_flags(input logic [31:0] r);
      logic exp_ones;
      logic exp_zero;
      logic man_zero;
      exp_ones = (r[30:23] == 8'hFF);
      exp_zero = (r[30:23] == 8'h00);
      man_zero = (r[22:0] == 23'd0);
      return {exp_ones && !man_zero, exp_ones && man_zero,
              exp_zero && man_zero, r[31]};
   endfunction
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         settle_cnt  <= 4'd0;
         fpu_a       <= 32'd0;
         fpu_b       <= 32'd0;
         fpu_control <= 1'b0;
         out_valid   <= 1'b0;
         out_result  <= 32'd0;
         op_count    <= 8'd0;
`ifdef FPU_RESULT_FLAGS_EN
         out_flags   <= 4'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  fpu_a       <= head[64:33];
                  fpu_b       <= head[32:1];
                  fpu_control <= head[0];
                  settle_cnt  <= SETTLE_LOAD;
                  state       <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == 4'd0) begin
                  out_result <= fpu_result;
`ifdef FPU_RESULT_FLAGS_EN
                  out_flags  <= result_flags(fpu_result);
`else
                  // no result flags in this build
`endif
                  out_valid  <= 1'b1;
                  state      <= HOLD;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  op_count  <= op_count + 8'd1;
                  if (pop) begin
                     fpu_a       <= head[64:33];
                     fpu_b       <= head[32:1];
                     fpu_control <= head[0];
                     settle_cnt  <= SETTLE_LOAD;
                     state       <= SETTLE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
